// File: rtl/dds_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dds_pkg
//  Description : Shared constants for the AD9954 configuration sequencer:
//                writer send codes, register indices, FSM state encoding and
//                the index-to-send-code lookup.
//  Revision    : 1.0  initial release
// ============================================================================
package dds_pkg;

  // Send codes understood by dds_write (0x10 + AD9954 register address)
  localparam logic [4:0] SEND_NONE  = 5'h00;
  localparam logic [4:0] SEND_CFR1  = 5'h10;
  localparam logic [4:0] SEND_CFR2  = 5'h11;
  localparam logic [4:0] SEND_ASF   = 5'h12;
  localparam logic [4:0] SEND_FTW0  = 5'h14;
  localparam logic [4:0] SEND_POW   = 5'h15;
  localparam logic [4:0] SEND_FTW1  = 5'h16;
  localparam logic [4:0] SEND_NLSCW = 5'h17;
  localparam logic [4:0] SEND_PLSCW = 5'h18;

  // Bit positions inside the configuration mask; lower index is written first
  localparam logic [2:0] IDX_CFR1  = 3'd0;
  localparam logic [2:0] IDX_CFR2  = 3'd1;
  localparam logic [2:0] IDX_ASF   = 3'd2;
  localparam logic [2:0] IDX_FTW0  = 3'd3;
  localparam logic [2:0] IDX_POW   = 3'd4;
  localparam logic [2:0] IDX_FTW1  = 3'd5;
  localparam logic [2:0] IDX_NLSCW = 3'd6;
  localparam logic [2:0] IDX_PLSCW = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ISSUE      = 3'd1,
    ST_WAIT_START = 3'd2,
    ST_WAIT_DONE  = 3'd3,
    ST_GAP        = 3'd4,
    ST_UPDATE     = 3'd5,
    ST_FINISH     = 3'd6
  } seq_state_e;

  // Map a mask bit index to the writer send code for that register
  function automatic logic [4:0] send_code(input logic [2:0] idx);
    logic [4:0] code;
    case (idx)
      IDX_CFR1:  code = SEND_CFR1;
      IDX_CFR2:  code = SEND_CFR2;
      IDX_ASF:   code = SEND_ASF;
      IDX_FTW0:  code = SEND_FTW0;
      IDX_POW:   code = SEND_POW;
      IDX_FTW1:  code = SEND_FTW1;
      IDX_NLSCW: code = SEND_NLSCW;
      default:   code = SEND_PLSCW;
    endcase
    return code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dds_mask_pick.sv
`default_nettype none
// ============================================================================
//  Module      : dds_mask_pick
//  Description : Combinational lowest-set-bit encoder. Returns the index of
//                the lowest pending register and whether any bit is set.
//  Revision    : 1.0  initial release
// ============================================================================
module dds_mask_pick (
  input  logic [7:0] mask_i,
  output logic       valid_o,
  output logic [2:0] idx_o
);

  // Scan from the top down so the last hit is the lowest set bit
  always_comb begin
    valid_o = 1'b0;
    idx_o   = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mask_i[i]) begin
        valid_o = 1'b1;
        idx_o   = 3'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dds_config_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : dds_config_sequencer
//  Description : Turns one masked configuration request into a fixed-order
//                series of dds_write send pulses, waits on the writer's cs
//                for each frame, and optionally pulses IO_UPDATE at the end.
//  Revision    : 1.0  initial release
// ============================================================================
module dds_config_sequencer
  import dds_pkg::*;
#(
  parameter int unsigned IO_UPDATE_CYCLES = 4,
  parameter int unsigned ACK_TIMEOUT      = 15,
  parameter int unsigned GAP_CYCLES       = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_req_i,
  input  logic [7:0] cfg_mask_i,
  input  logic       cfg_update_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       error_o,
  output logic [4:0] send_o,
  input  logic       dds_cs_i,
  output logic       io_update_o
);

  localparam logic [7:0] C_ACK_LOAD   = 8'(ACK_TIMEOUT);
  localparam logic [3:0] C_GAP_LOAD   = 4'(GAP_CYCLES);
  localparam logic [3:0] C_PULSE_LOAD = 4'(IO_UPDATE_CYCLES);

  seq_state_e state_q;
  logic [7:0] mask_q;
  logic       update_q;
  logic [7:0] timeout_q;
  logic [3:0] gap_q;
  logic [3:0] pulse_q;
  logic       busy_q;
  logic       done_q;
  logic       error_q;
  logic [4:0] send_q;
  logic       io_update_q;

  logic       pick_valid_d;
  logic [2:0] pick_idx_d;

  dds_mask_pick u_pick (
    .mask_i  (mask_q),
    .valid_o (pick_valid_d),
    .idx_o   (pick_idx_d)
  );

  // Sequencer FSM with its counters and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mask_q      <= 8'd0;
      update_q    <= 1'b0;
      timeout_q   <= 8'd0;
      gap_q       <= 4'd0;
      pulse_q     <= 4'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      send_q      <= SEND_NONE;
      io_update_q <= 1'b0;
    end else begin
      // send and done are single-cycle strobes
      send_q <= SEND_NONE;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // dds_cs_i is deliberately not looked at here
          if (cfg_req_i) begin
            mask_q   <= cfg_mask_i;
            update_q <= cfg_update_i;
            error_q  <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (pick_valid_d) begin
            send_q    <= send_code(pick_idx_d);
            mask_q    <= mask_q & ~(8'd1 << pick_idx_d);
            timeout_q <= C_ACK_LOAD;
            state_q   <= ST_WAIT_START;
          end else if (update_q) begin
            io_update_q <= 1'b1;
            pulse_q     <= C_PULSE_LOAD;
            state_q     <= ST_UPDATE;
          end else begin
            state_q <= ST_FINISH;
          end
        end
        ST_WAIT_START: begin
          if (!dds_cs_i) begin
            state_q <= ST_WAIT_DONE;
          end else if (timeout_q <= 8'd1) begin
            // Writer never acknowledged: drop remaining registers, skip update
            timeout_q <= 8'd0;
            error_q   <= 1'b1;
            mask_q    <= 8'd0;
            state_q   <= ST_FINISH;
          end else begin
            timeout_q <= timeout_q - 8'd1;
          end
        end
        ST_WAIT_DONE: begin
          if (dds_cs_i) begin
            gap_q   <= C_GAP_LOAD;
            state_q <= ST_GAP;
          end
        end
        ST_GAP: begin
          // A zero gap still spends one cycle here
          if (gap_q <= 4'd1) begin
            state_q <= ST_ISSUE;
          end else begin
            gap_q <= gap_q - 4'd1;
          end
        end
        ST_UPDATE: begin
          if (pulse_q <= 4'd1) begin
            io_update_q <= 1'b0;
            pulse_q     <= 4'd0;
            state_q     <= ST_FINISH;
          end else begin
            pulse_q <= pulse_q - 4'd1;
          end
        end
        ST_FINISH: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign error_o     = error_q;
  assign send_o      = send_q;
  assign io_update_o = io_update_q;

endmodule
`default_nettype wire
